// File: rtl/code_rx_deframer.sv
// code_rx_deframer: recovers 8-bit MSB-first code words from an idle-low serial line.
// Bit 7 of every legal code is 1 and doubles as the start bit.
// Optional macro CODE_RX_STOP_CHECK_EN adds a ninth (stop) bit sample; a high stop bit
// is reported as a framing error.
module code_rx_deframer #(
  parameter int unsigned BIT_CYCLES = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic [7:0] code,
  output logic [1:0] symbol,
  output logic       code_valid,
  output logic       code_error,
  output logic       busy
);

  localparam logic [CNT_W-1:0] L_HALF_M1 = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] L_FULL_M1 = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef CODE_RX_STOP_CHECK_EN
    S_STOP,
`endif
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_rx_s, r_prev_s;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [7:0]       r_code, w_code_nxt;
  logic [1:0]       r_symbol, w_symbol_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_error, w_error_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_cnt_zero;
  logic             w_legal;
  logic [1:0]       w_sym;
  logic             w_ok;

`ifdef CODE_RX_STOP_CHECK_EN
  logic             r_ferr, w_ferr_nxt;
  assign w_ok = w_legal && !r_ferr;
`else
  assign w_ok = w_legal;
`endif

  assign w_cnt_zero = (r_cnt == '0);

  assign code       = r_code;
  assign symbol     = r_symbol;
  assign code_valid = r_valid;
  assign code_error = r_error;
  assign busy       = r_busy;

  // Legal code word lookup
  always_comb begin
    w_legal = 1'b1;
    w_sym   = 2'd0;
    case (r_shift)
      8'h80:   w_sym = 2'd0;
      8'hA0:   w_sym = 2'd1;
      8'hA8:   w_sym = 2'd2;
      8'hAA:   w_sym = 2'd3;
      default: w_legal = 1'b0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_code_nxt   = r_code;
    w_symbol_nxt = r_symbol;
    w_valid_nxt  = 1'b0;
    w_error_nxt  = 1'b0;
`ifdef CODE_RX_STOP_CHECK_EN
    w_ferr_nxt   = r_ferr;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_rx_s && !r_prev_s) begin
          w_cnt_nxt   = L_HALF_M1;
          w_state_nxt = S_START;
`ifdef CODE_RX_STOP_CHECK_EN
          w_ferr_nxt  = 1'b0;
`endif
        end
      end
      S_START: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (r_rx_s) begin
          w_shift_nxt = 8'h80;
          w_idx_nxt   = 3'd6;
          w_cnt_nxt   = L_FULL_M1;
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_shift_nxt[r_idx] = r_rx_s;
          w_cnt_nxt          = L_FULL_M1;
          if (r_idx == 3'd0) begin
`ifdef CODE_RX_STOP_CHECK_EN
            w_state_nxt = S_STOP;
`else
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_idx_nxt = r_idx - 3'd1;
          end
        end
      end
`ifdef CODE_RX_STOP_CHECK_EN
      S_STOP: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_ferr_nxt  = r_rx_s;
          w_state_nxt = S_DONE;
        end
      end
`endif
      S_DONE: begin
        w_code_nxt = r_shift;
        if (w_ok) begin
          w_symbol_nxt = w_sym;
          w_valid_nxt  = 1'b1;
        end else begin
          w_error_nxt = 1'b1;
        end
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State, synchronizer and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_sync1  <= 1'b0;
      r_rx_s   <= 1'b0;
      r_prev_s <= 1'b0;
      r_cnt    <= '0;
      r_idx    <= 3'd0;
      r_shift  <= 8'h00;
      r_code   <= 8'h00;
      r_symbol <= 2'd0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
      r_busy   <= 1'b0;
`ifdef CODE_RX_STOP_CHECK_EN
      r_ferr   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_sync1  <= rx_in;
      r_rx_s   <= r_sync1;
      r_prev_s <= r_rx_s;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_code   <= w_code_nxt;
      r_symbol <= w_symbol_nxt;
      r_valid  <= w_valid_nxt;
      r_error  <= w_error_nxt;
      r_busy   <= w_busy_nxt;
`ifdef CODE_RX_STOP_CHECK_EN
      r_ferr   <= w_ferr_nxt;
`endif
    end
  end

endmodule
